// File: rtl/ipm_core_rotator.sv
`default_nettype none
// ============================================================================
// Module   : ipm_core_rotator
// Brief    : Input FIFO -> iterative rotate-left FSM -> show-ahead output FIFO,
//            driven by one-cycle MCU write/read/start strobes.
//            Optional sticky error flags: define IPM_CORE_ERR_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ipm_core_rotator #(
    parameter int DATA_WIDTH = 32,
    parameter int CONF_WIDTH = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  clk_n_Hz,
    input  logic                  rst_sync_high,
    input  logic [DATA_WIDTH-1:0] dataInIPi,
    input  logic [CONF_WIDTH-1:0] configIPi,
    input  logic                  writeIPi,
    input  logic                  readIPi,
    input  logic                  startIPi,
    output logic [DATA_WIDTH-1:0] dataOutIPo,
    output logic                  busyIPo,
    output logic                  doneIPo,
    output logic [PTR_WIDTH:0]    inLevelIPo,
    output logic [PTR_WIDTH:0]    outLevelIPo,
    output logic [1:0]            errIPo
);

    localparam logic [PTR_WIDTH:0]    c_full    = (PTR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0]  c_ptr_one = PTR_WIDTH'(1);
    localparam logic [CONF_WIDTH-1:0] c_cnt_one = CONF_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STORE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t                r_state;
    logic [CONF_WIDTH-1:0] r_amt;
    logic [CONF_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_work;

    logic [DATA_WIDTH-1:0] r_in_mem [0:FIFO_DEPTH-1];
    logic [PTR_WIDTH-1:0]  r_in_wr;
    logic [PTR_WIDTH-1:0]  r_in_rd;
    logic [PTR_WIDTH:0]    r_in_lvl;

    logic [DATA_WIDTH-1:0] r_out_mem [0:FIFO_DEPTH-1];
    logic [PTR_WIDTH-1:0]  r_out_wr;
    logic [PTR_WIDTH-1:0]  r_out_rd;
    logic [PTR_WIDTH:0]    r_out_lvl;

    logic w_in_full;
    logic w_in_empty;
    logic w_out_full;
    logic w_out_empty;
    logic w_in_push;
    logic w_in_pop;
    logic w_out_push;
    logic w_out_pop;
    logic w_start_ok;

    assign w_in_full   = (r_in_lvl == c_full);
    assign w_in_empty  = (r_in_lvl == '0);
    assign w_out_full  = (r_out_lvl == c_full);
    assign w_out_empty = (r_out_lvl == '0);

    // Full/empty are taken from registered levels, so a same-cycle MCU pop
    // never makes room for an FSM push until the following cycle.
    assign w_in_push   = writeIPi && !w_in_full;
    assign w_in_pop    = (r_state == ST_FETCH) && !w_in_empty;
    assign w_out_push  = (r_state == ST_STORE) && !w_out_full;
    assign w_out_pop   = readIPi && !w_out_empty;
    assign w_start_ok  = (r_state == ST_IDLE) && startIPi;

    // Storage arrays carry no reset; emptiness is defined by the pointers.
    always_ff @(posedge clk_n_Hz) begin
        if (!rst_sync_high && w_in_push) begin
            r_in_mem[r_in_wr] <= dataInIPi;
        end
        if (!rst_sync_high && w_out_push) begin
            r_out_mem[r_out_wr] <= r_work;
        end
    end

    always_ff @(posedge clk_n_Hz) begin
        if (rst_sync_high) begin
            r_in_wr   <= '0;
            r_in_rd   <= '0;
            r_in_lvl  <= '0;
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_lvl <= '0;
        end else begin
            if (w_in_push)  r_in_wr  <= r_in_wr + c_ptr_one;
            if (w_in_pop)   r_in_rd  <= r_in_rd + c_ptr_one;
            if (w_out_push) r_out_wr <= r_out_wr + c_ptr_one;
            if (w_out_pop)  r_out_rd <= r_out_rd + c_ptr_one;
            r_in_lvl  <= r_in_lvl  + {{PTR_WIDTH{1'b0}}, w_in_push}
                                   - {{PTR_WIDTH{1'b0}}, w_in_pop};
            r_out_lvl <= r_out_lvl + {{PTR_WIDTH{1'b0}}, w_out_push}
                                   - {{PTR_WIDTH{1'b0}}, w_out_pop};
        end
    end

    always_ff @(posedge clk_n_Hz) begin
        if (rst_sync_high) begin
            r_state <= ST_IDLE;
            r_amt   <= '0;
            r_cnt   <= '0;
            r_work  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (startIPi) begin
                        r_amt   <= configIPi;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_in_empty) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_work  <= r_in_mem[r_in_rd];
                        r_cnt   <= r_amt;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_STORE;
                    end else begin
                        r_work <= {r_work[DATA_WIDTH-2:0], r_work[DATA_WIDTH-1]};
                        r_cnt  <= r_cnt - c_cnt_one;
                    end
                end
                ST_STORE: begin
                    if (!w_out_full) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IPM_CORE_ERR_FLAGS_EN
    logic [1:0] r_err;

    // Clear first, then set: a set event coinciding with a start wins.
    always_ff @(posedge clk_n_Hz) begin
        if (rst_sync_high) begin
            r_err <= 2'b00;
        end else begin
            if (w_start_ok)              r_err    <= 2'b00;
            if (writeIPi && w_in_full)   r_err[0] <= 1'b1;
            if (readIPi && w_out_empty)  r_err[1] <= 1'b1;
        end
    end

    assign errIPo = r_err;
`else
    assign errIPo = 2'b00;
`endif

    assign dataOutIPo  = w_out_empty ? '0 : r_out_mem[r_out_rd];
    assign busyIPo     = (r_state != ST_IDLE);
    assign doneIPo     = (r_state == ST_FIN);
    assign inLevelIPo  = r_in_lvl;
    assign outLevelIPo = r_out_lvl;

endmodule
`default_nettype wire

// File: tb/tb_ipm_core_rotator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipm_core_rotator
// Brief    : Self-checking bench for ipm_core_rotator against a queue-based
//            reference model; directed scenarios plus randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipm_core_rotator;

    logic        clk = 1'b0;
    logic        rst_sync_high;
    logic [31:0] dataInIPi;
    logic [4:0]  configIPi;
    logic        writeIPi;
    logic        readIPi;
    logic        startIPi;
    logic [31:0] dataOutIPo;
    logic        busyIPo;
    logic        doneIPo;
    logic [3:0]  inLevelIPo;
    logic [3:0]  outLevelIPo;
    logic [1:0]  errIPo;

    always #5 clk = ~clk;

    ipm_core_rotator dut (
        .clk_n_Hz      (clk),
        .rst_sync_high (rst_sync_high),
        .dataInIPi     (dataInIPi),
        .configIPi     (configIPi),
        .writeIPi      (writeIPi),
        .readIPi       (readIPi),
        .startIPi      (startIPi),
        .dataOutIPo    (dataOutIPo),
        .busyIPo       (busyIPo),
        .doneIPo       (doneIPo),
        .inLevelIPo    (inLevelIPo),
        .outLevelIPo   (outLevelIPo),
        .errIPo        (errIPo)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Reference model: queues for the FIFOs, a run flag, and a per-word timer.
    logic [31:0] m_in_q[$];
    logic [31:0] m_out_q[$];
    bit          m_active = 0;
    bit          m_fin    = 0;
    bit          m_have   = 0;
    int          m_wait   = 0;
    int          m_amt    = 0;
    logic [31:0] m_res    = '0;
    logic [1:0]  m_err    = 2'b00;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int a);
        if (a == 0) return x;
        return (x << a) | (x >> (32 - a));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rs, input logic w, input logic r, input logic s,
                              input logic [31:0] d, input logic [4:0] c);
        int  nin;
        int  nout;
        bit  push_out;
        if (rs) begin
            m_in_q.delete();
            m_out_q.delete();
            m_active = 0;
            m_fin    = 0;
            m_have   = 0;
            m_wait   = 0;
            m_err    = 2'b00;
            return;
        end
        nin      = m_in_q.size();
        nout     = m_out_q.size();
        push_out = 0;
        if (!m_active && s) m_err = 2'b00;
        if (w && nin == 8)  m_err[0] = 1'b1;
        if (r && nout == 0) m_err[1] = 1'b1;
        if (m_fin) begin
            m_fin    = 0;
            m_active = 0;
        end else if (m_active) begin
            if (!m_have) begin
                if (nin == 0) begin
                    m_fin = 1;
                end else begin
                    m_res  = rotl(m_in_q.pop_front(), m_amt);
                    m_wait = m_amt + 1;
                    m_have = 1;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (nout < 8) begin
                push_out = 1;
                m_have   = 0;
            end
        end else if (s) begin
            m_active = 1;
            m_amt    = int'(c);
        end
        if (w && nin < 8)  m_in_q.push_back(d);
        if (r && nout > 0) void'(m_out_q.pop_front());
        if (push_out)      m_out_q.push_back(m_res);
    endtask

    task automatic compare_all();
        logic [1:0]  exp_err;
        logic [31:0] exp_data;
`ifdef IPM_CORE_ERR_FLAGS_EN
        exp_err = m_err;
`else
        exp_err = 2'b00;
`endif
        exp_data = (m_out_q.size() > 0) ? m_out_q[0] : 32'h0;
        chk("busy",      {31'd0, busyIPo}, {31'd0, m_active});
        chk("done",      {31'd0, doneIPo}, {31'd0, m_fin});
        chk("in_level",  {28'd0, inLevelIPo},  32'(m_in_q.size()));
        chk("out_level", {28'd0, outLevelIPo}, 32'(m_out_q.size()));
        chk("data_out",  dataOutIPo, exp_data);
        chk("err",       {30'd0, errIPo}, {30'd0, exp_err});
    endtask

    task automatic step(input logic rs, input logic w, input logic r, input logic s,
                        input logic [31:0] d, input logic [4:0] c);
        rst_sync_high = rs;
        writeIPi      = w;
        readIPi       = r;
        startIPi      = s;
        dataInIPi     = d;
        configIPi     = c;
        @(posedge clk);
        model_step(rs, w, r, s, d, c);
        @(negedge clk);
        compare_all();
        if (doneIPo) done_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 5'd0);
    endtask

    task automatic wr(input logic [31:0] d);
        step(0, 1, 0, 0, d, 5'd0);
    endtask

    task automatic rd();
        step(0, 0, 1, 0, 32'h0, 5'd0);
    endtask

    task automatic start(input logic [4:0] c);
        step(0, 0, 0, 1, 32'h0, c);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 32'h0, 5'd0);
        step(1, 0, 0, 0, 32'h0, 5'd0);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busyIPo; i++) idle(1);
        chk("idle_timeout", {31'd0, busyIPo}, 32'd0);
    endtask

    initial begin
        int d0;
        rst_sync_high = 1'b1;
        writeIPi = 1'b0; readIPi = 1'b0; startIPi = 1'b0;
        dataInIPi = '0;  configIPi = '0;
        @(negedge clk);

        // Reset state and the basic single-word run.
        do_reset();
        chk("rst_data",  dataOutIPo, 32'h0);
        chk("rst_level", {28'd0, outLevelIPo}, 32'd0);
        wr(32'h8000_0001);
        d0 = done_cnt;
        start(5'd1);
        chk("busy_after_start", {31'd0, busyIPo}, 32'd1);
        idle(4);
        chk("t1_level", {28'd0, outLevelIPo}, 32'd1);
        chk("t1_data",  dataOutIPo, 32'h0000_0003);
        wait_idle(20);
        chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
        rd();

        // Pass-through with amount 0, then pop back to empty.
        wr(32'h1234_5678);
        start(5'd0);
        wait_idle(20);
        chk("t2_data", dataOutIPo, 32'h1234_5678);
        rd();
        chk("t2_level", {28'd0, outLevelIPo}, 32'd0);
        chk("t2_empty_data", dataOutIPo, 32'h0);

        // Amount 31 equals rotate right by one.
        wr(32'h0000_0001);
        start(5'd31);
        wait_idle(60);
        chk("t_amt31", dataOutIPo, 32'h8000_0000);
        rd();

        // Overflow the input FIFO, then rotate every word by 4.
        do_reset();
        for (int i = 0; i < 9; i++) wr(32'(i));
        chk("t3_in_full", {28'd0, inLevelIPo}, 32'd8);
`ifdef IPM_CORE_ERR_FLAGS_EN
        chk("t3_err_ovf", {30'd0, errIPo}, 32'd1);
`endif
        start(5'd4);
        wait_idle(200);
        chk("t3_out_full", {28'd0, outLevelIPo}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t3_data", dataOutIPo, 32'(i) << 4);
            rd();
        end
        rd();

        // Output FIFO full: the run stalls in STORE until one slot frees.
        do_reset();
        for (int i = 0; i < 8; i++) wr(32'h100 + 32'(i));
        start(5'd0);
        wait_idle(100);
        wr(32'hABCD_0000);
        d0 = done_cnt;
        start(5'd0);
        idle(10);
        chk("t4_stall_busy",  {31'd0, busyIPo}, 32'd1);
        chk("t4_stall_level", {28'd0, outLevelIPo}, 32'd8);
        rd();
        chk("t4_after_pop", {28'd0, outLevelIPo}, 32'd7);
        idle(1);
        chk("t4_pushed", {28'd0, outLevelIPo}, 32'd8);
        wait_idle(20);
        chk("t4_done_once", 32'(done_cnt - d0), 32'd1);
        for (int i = 0; i < 7; i++) rd();
        chk("t4_last", dataOutIPo, 32'hABCD_0000);
        rd();

        // Start pulses during a run are ignored.
        wr(32'h0000_0001);
        wr(32'hF000_0000);
        d0 = done_cnt;
        start(5'd3);
        idle(2);
        start(5'd7);
        idle(5);
        start(5'd7);
        wait_idle(100);
        chk("t5_done_once", 32'(done_cnt - d0), 32'd1);
        chk("t5_w0", dataOutIPo, 32'h0000_0008);
        rd();
        chk("t5_w1", dataOutIPo, 32'h8000_0007);
        rd();

        // Reset while shifting discards everything and emits no done.
        wr(32'h5555_0000);
        start(5'd20);
        idle(3);
        d0 = done_cnt;
        step(1, 0, 0, 0, 32'h0, 5'd0);
        chk("t6_busy",  {31'd0, busyIPo}, 32'd0);
        chk("t6_in",    {28'd0, inLevelIPo}, 32'd0);
        chk("t6_out",   {28'd0, outLevelIPo}, 32'd0);
        chk("t6_data",  dataOutIPo, 32'h0);
        idle(25);
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0),
                 $urandom(),
                 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
